// File: rtl/hash_state_bank.sv
// SHA-2 chaining-state bank: loads the mode IV, folds each block's working variables into H
// (feed-forward add), chains across blocks and hands the truncated digest out on valid/ready.
module hash_state_bank #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned LANES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    msg_start,
  input  logic [1:0]              hash_size,
  input  logic                    wv_valid,
  output logic                    wv_ready,
  input  logic [LANES*WORD_W-1:0] wv_data,
  input  logic                    wv_last_blk,
  output logic [8*WORD_W-1:0]     h_state,
  output logic                    blk_done,
  output logic                    digest_valid,
  input  logic                    digest_ready,
  output logic [511:0]            digest,
  output logic                    err
);

  localparam int unsigned BEATS = 8 / LANES;
  localparam logic [2:0] LastBeat = 3'(BEATS - 1);
  localparam logic [WORD_W-1:0] Mask32 = WORD_W'(64'h0000_0000_ffff_ffff);

  localparam logic [0:7][63:0] Iv512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [0:7][63:0] Iv384 = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
  localparam logic [0:7][63:0] Iv256 = {
    64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'ha54ff53a,
    64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19};
  localparam logic [0:7][63:0] Iv224 = {
    64'hc1059ed8, 64'h367cd507, 64'h3070dd17, 64'hf70e5939,
    64'hffc00b31, 64'h68581511, 64'h64f98fa7, 64'hbefa4fa4};

  typedef enum logic [1:0] {StIdle, StAccum, StDigest} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] h_q [8];
  logic [WORD_W-1:0] h_d [8];
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        beat_q, beat_d;
  logic              blk_done_q, blk_done_d;
  logic              err_q, err_d;
  logic              illegal;
  logic              narrow;

  function automatic logic [63:0] iv_word(input logic [1:0] mode, input int unsigned k);
    logic [63:0] w;
    case (mode)
      2'b00:   w = Iv512[3'(k)];
      2'b10:   w = Iv384[3'(k)];
      2'b01:   w = Iv256[3'(k)];
      default: w = Iv224[3'(k)];
    endcase
    return w;
  endfunction

  // A 32-bit bank cannot hold the 64-bit families (hash_size[0]==0).
  assign illegal = (WORD_W == 32) && !hash_size[0];
  assign narrow  = mode_q[0];

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    beat_d     = beat_q;
    err_d      = err_q;
    blk_done_d = 1'b0;
    for (int unsigned k = 0; k < 8; k++) h_d[k] = h_q[k];

    if (msg_start) begin
      beat_d = '0;
      if (illegal) begin
        err_d   = 1'b1;
        state_d = StIdle;
      end else begin
        err_d   = 1'b0;
        mode_d  = hash_size;
        state_d = StAccum;
        for (int unsigned k = 0; k < 8; k++) h_d[k] = WORD_W'(iv_word(hash_size, k));
      end
    end else begin
      case (state_q)
        StAccum: begin
          if (wv_valid) begin
            for (int unsigned k = 0; k < 8; k++) begin
              if (3'(k / LANES) == beat_q) begin
                h_d[k] = (h_q[k] + wv_data[(k % LANES)*WORD_W +: WORD_W])
                         & (narrow ? Mask32 : '1);
              end
            end
            if (beat_q == LastBeat) begin
              beat_d     = '0;
              blk_done_d = 1'b1;
              if (wv_last_blk) state_d = StDigest;
            end else begin
              beat_d = beat_q + 3'd1;
            end
          end
        end
        StDigest: if (digest_ready) state_d = StIdle;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      mode_q     <= 2'b01;
      beat_q     <= '0;
      blk_done_q <= 1'b0;
      err_q      <= 1'b0;
      for (int unsigned k = 0; k < 8; k++) h_q[k] <= WORD_W'(Iv256[k]);
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      beat_q     <= beat_d;
      blk_done_q <= blk_done_d;
      err_q      <= err_d;
      for (int unsigned k = 0; k < 8; k++) h_q[k] <= h_d[k];
    end
  end

  assign wv_ready     = (state_q == StAccum);
  assign digest_valid = (state_q == StDigest);
  assign blk_done     = blk_done_q;
  assign err          = err_q;

  always_comb begin
    for (int unsigned k = 0; k < 8; k++) h_state[(7-k)*WORD_W +: WORD_W] = h_q[k];
  end

  // Digest is driven only while offered so it reads zero outside DIGEST.
  always_comb begin
    digest = '0;
    if (state_q == StDigest) begin
      case (mode_q)
        2'b00: for (int unsigned k = 0; k < 8; k++) digest[(7-k)*64 +: 64] = 64'(h_q[k]);
        2'b10: for (int unsigned k = 0; k < 6; k++) digest[(5-k)*64 +: 64] = 64'(h_q[k]);
        2'b01: for (int unsigned k = 0; k < 8; k++) digest[(7-k)*32 +: 32] = h_q[k][31:0];
        default: for (int unsigned k = 0; k < 7; k++) digest[(6-k)*32 +: 32] = h_q[k][31:0];
      endcase
    end
  end

endmodule

// File: tb/tb_hash_state_bank.sv
// Bench for hash_state_bank: directed corner cases plus random multi-block messages checked
// against a whole-block arithmetic model of the chaining value and digest.
module tb_hash_state_bank;

  localparam int unsigned W  = 64;
  localparam int unsigned L  = 2;
  localparam int unsigned NB = 8 / L;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           msg_start = 1'b0;
  logic [1:0]     hash_size = 2'b00;
  logic           wv_valid = 1'b0;
  logic           wv_ready;
  logic [L*W-1:0] wv_data = '0;
  logic           wv_last_blk = 1'b0;
  logic [8*W-1:0] h_state;
  logic           blk_done, digest_valid;
  logic           digest_ready = 1'b0;
  logic [511:0]   digest;
  logic           err;

  logic           s_msg_start = 1'b0;
  logic [1:0]     s_hash_size = 2'b00;
  logic           s_wv_ready, s_blk_done, s_digest_valid, s_err;
  logic [255:0]   s_h_state;
  logic [511:0]   s_digest;

  hash_state_bank #(.WORD_W(W), .LANES(L)) dut (
    .clk(clk), .rst(rst), .msg_start(msg_start), .hash_size(hash_size),
    .wv_valid(wv_valid), .wv_ready(wv_ready), .wv_data(wv_data), .wv_last_blk(wv_last_blk),
    .h_state(h_state), .blk_done(blk_done), .digest_valid(digest_valid),
    .digest_ready(digest_ready), .digest(digest), .err(err)
  );

  hash_state_bank #(.WORD_W(32), .LANES(4)) dut32 (
    .clk(clk), .rst(rst), .msg_start(s_msg_start), .hash_size(s_hash_size),
    .wv_valid(1'b0), .wv_ready(s_wv_ready), .wv_data(128'h0), .wv_last_blk(1'b0),
    .h_state(s_h_state), .blk_done(s_blk_done), .digest_valid(s_digest_valid),
    .digest_ready(1'b0), .digest(s_digest), .err(s_err)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [63:0] hm [8];
  logic [1:0]  mm;
  logic [63:0] wblk [8];
  logic [511:0] held;

  localparam logic [0:7][63:0] T512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [0:7][63:0] T384 = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
  localparam logic [0:7][31:0] T256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [0:7][31:0] T224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start(input logic [1:0] mode);
    mm = mode;
    for (int k = 0; k < 8; k++) begin
      case (mode)
        2'b00:   hm[k] = T512[k];
        2'b10:   hm[k] = T384[k];
        2'b01:   hm[k] = {32'h0, T256[k]};
        default: hm[k] = {32'h0, T224[k]};
      endcase
    end
  endtask

  task automatic model_block();
    for (int k = 0; k < 8; k++) begin
      if (mm[0]) hm[k] = {32'h0, hm[k][31:0] + wblk[k][31:0]};
      else       hm[k] = hm[k] + wblk[k];
    end
  endtask

  function automatic logic [511:0] exp_state();
    return {hm[0], hm[1], hm[2], hm[3], hm[4], hm[5], hm[6], hm[7]};
  endfunction

  function automatic logic [511:0] exp_digest();
    case (mm)
      2'b00: return {hm[0], hm[1], hm[2], hm[3], hm[4], hm[5], hm[6], hm[7]};
      2'b10: return {128'h0, hm[0], hm[1], hm[2], hm[3], hm[4], hm[5]};
      2'b01: return {256'h0, hm[0][31:0], hm[1][31:0], hm[2][31:0], hm[3][31:0],
                     hm[4][31:0], hm[5][31:0], hm[6][31:0], hm[7][31:0]};
      default: return {288'h0, hm[0][31:0], hm[1][31:0], hm[2][31:0], hm[3][31:0],
                       hm[4][31:0], hm[5][31:0], hm[6][31:0]};
    endcase
  endfunction

  task automatic start(input logic [1:0] mode);
    msg_start = 1'b1;
    hash_size = mode;
    tick();
    msg_start = 1'b0;
    model_start(mode);
    check("start_state", h_state, exp_state());
    check("start_ready", wv_ready, 1'b1);
  endtask

  task automatic fill_words(input logic [63:0] v, input bit rnd);
    for (int k = 0; k < 8; k++) wblk[k] = rnd ? {$urandom(), $urandom()} : v;
  endtask

  task automatic send_block(input bit last, input bit gaps);
    for (int b = 0; b < NB; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        wv_valid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      check("beat_ready", wv_ready, 1'b1);
      wv_valid = 1'b1;
      for (int i = 0; i < L; i++) wv_data[i*W +: W] = wblk[b*L+i];
      wv_last_blk = (b == NB - 1) ? last : 1'($urandom_range(0, 1));
      tick();
      check("blk_done_beat", blk_done, (b == NB - 1));
    end
    wv_valid    = 1'b0;
    wv_last_blk = 1'b0;
    model_block();
    check("ff_state", h_state, exp_state());
    tick();
    check("blk_done_clr", blk_done, 1'b0);
    check("after_blk_valid", digest_valid, last);
    check("after_blk_ready", wv_ready, !last);
  endtask

  task automatic finish_digest(input int unsigned delay);
    held = digest;
    check("dig_valid", digest_valid, 1'b1);
    check("dig_value", digest, exp_digest());
    for (int c = 0; c < int'(delay); c++) begin
      tick();
      check("bp_valid", digest_valid, 1'b1);
      check("bp_stable", digest, held);
    end
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    check("xfer_valid", digest_valid, 1'b0);
    check("xfer_idle", wv_ready, 1'b0);
    check("xfer_hold", h_state, exp_state());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    model_start(2'b01);
    check("rst_state", h_state, exp_state());
    check("rst_h0", h_state[511:448], 64'h0000_0000_6a09e667);
    check("rst_ready", wv_ready, 1'b0);
    check("rst_valid", digest_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_blk", blk_done, 1'b0);
    check("rst_digest", digest, '0);
    rst = 1'b1;

    // 32-bit instance: 64-bit families rejected, 224 accepted.
    check("w32_rst_err", s_err, 1'b0);
    check("w32_rst_state", s_h_state, {T256[0], T256[1], T256[2], T256[3],
                                       T256[4], T256[5], T256[6], T256[7]});
    for (int m = 0; m < 2; m++) begin
      s_msg_start = 1'b1;
      s_hash_size = (m == 0) ? 2'b00 : 2'b10;
      tick();
      s_msg_start = 1'b0;
      check("w32_err", s_err, 1'b1);
      check("w32_idle", s_wv_ready, 1'b0);
      check("w32_h_kept", s_h_state, {T256[0], T256[1], T256[2], T256[3],
                                      T256[4], T256[5], T256[6], T256[7]});
    end
    s_msg_start = 1'b1;
    s_hash_size = 2'b11;
    tick();
    s_msg_start = 1'b0;
    check("w32_err_clr", s_err, 1'b0);
    check("w32_accum", s_wv_ready, 1'b1);
    check("w32_iv224", s_h_state, {T224[0], T224[1], T224[2], T224[3],
                                   T224[4], T224[5], T224[6], T224[7]});

    // SHA-256 single block of ones.
    start(2'b01);
    fill_words(64'h1, 1'b0);
    send_block(1'b1, 1'b0);
    check("s256_hi", digest[255:224], 32'h6a09e668);
    check("s256_lo", digest[31:0], 32'h5be0cd1a);
    check("s256_pad", digest[511:256], '0);
    finish_digest(0);

    // 32-bit wrap with upper garbage ignored.
    start(2'b01);
    fill_words(64'h0, 1'b0);
    wblk[0] = 64'hffff_ffff_ffff_ffff;
    send_block(1'b1, 1'b0);
    check("wrap_h0", h_state[511:448], 64'h0000_0000_6a09e666);
    finish_digest(1);

    // 64-bit carry stays inside the word.
    start(2'b00);
    fill_words(64'h0, 1'b0);
    wblk[0] = 64'h0000_0000_0c43_36f8;
    send_block(1'b1, 1'b0);
    check("carry_h0", h_state[511:448], 64'h6a09e668_00000000);
    finish_digest(0);

    // Two-block SHA-224, then backpressure.
    start(2'b11);
    fill_words(64'h1, 1'b0);
    send_block(1'b0, 1'b0);
    send_block(1'b1, 1'b0);
    check("s224_h0", digest[223:192], 32'hc1059eda);
    check("s224_pad", digest[255:224], 32'h0);
    finish_digest(10);

    // Abort on beat 2 with a SHA-384 restart.
    start(2'b00);
    for (int b = 0; b < 3; b++) begin
      wv_valid = 1'b1;
      wv_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (b == 2) begin
        msg_start = 1'b1;
        hash_size = 2'b10;
      end
      tick();
    end
    msg_start = 1'b0;
    wv_valid  = 1'b0;
    model_start(2'b10);
    check("abort_state", h_state, exp_state());
    check("abort_ready", wv_ready, 1'b1);
    fill_words(64'h0, 1'b1);
    send_block(1'b1, 1'b0);
    finish_digest(2);

    // Beats in IDLE are ignored.
    wv_valid = 1'b1;
    wv_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
    wv_valid = 1'b0;
    check("idle_state", h_state, exp_state());
    check("idle_blk", blk_done, 1'b0);

    // Random messages.
    for (int m = 0; m < 20; m++) begin
      int unsigned nblk;
      start(2'($urandom_range(0, 3)));
      nblk = $urandom_range(1, 3);
      for (int b = 0; b < int'(nblk); b++) begin
        fill_words(64'h0, 1'b1);
        send_block(b == int'(nblk) - 1, 1'b1);
      end
      finish_digest($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hash_state_bank.md
Name: hash_state_bank

Overview:
- Parametrised SHA-2 chaining-state register bank; successor to the fixed two-chain IV/shift block.
- Loads the IV for SHA-224/256/384/512 and accepts working variables a..h in LANES words per beat.
- Performs the per-block feed-forward add internally, modulo the family word size, and chains the result across blocks.
- Presents the truncated final digest on a valid/ready handshake. Sits between the round engine and the signature/compare logic.

Parameters:
- WORD_W, 64, storage word width; legal values 32 (SHA-224/256 only) or 64 (all modes).
- LANES, 2, words accepted per beat; legal values 1, 2, 4, 8. BEATS = 8/LANES.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- msg_start  in  1  start message: load IV for hash_size, abort any operation in progress.
- hash_size  in  2  mode, sampled on msg_start only: 00 SHA-512, 01 SHA-256, 10 SHA-384, 11 SHA-224.
- wv_valid  in  1  working-variable beat valid.
- wv_ready  out  1  bank accepts a beat.
- wv_data  in  LANES*WORD_W  lane i (bits [i*WORD_W +: WORD_W]) = working var index beat*LANES+i (0=a .. 7=h).
- wv_last_blk  in  1  qualifies the final beat of the message's last block.
- h_state  out  8*WORD_W  current chaining value {H0..H7}, H0 in MSBs.
- blk_done  out  1  one-cycle pulse after each block's feed-forward completes.
- digest_valid  out  1  final digest available.
- digest_ready  in  1  consumer accepts digest.
- digest  out  512  truncated digest, right-aligned, H0 most significant, unused MSBs zero.
- err  out  1  sticky illegal-mode flag, cleared by msg_start or reset.

Behaviour:
- Reset (rst==0 at posedge clk): H0..H7 = SHA-256 IV zero-extended; FSM IDLE; beat_cnt=0; wv_ready=0, blk_done=0, digest_valid=0, err=0; digest output = 0.
- FSM states: IDLE, ACCUM, DIGEST.
- msg_start has priority over all other inputs in every state:
  - Loads the mode IV into H0..H7; latches the mode; beat_cnt=0; next state ACCUM; clears err and digest_valid.
  - A wv beat presented in the same cycle is dropped.
- IVs:
  - SHA-512 and SHA-384 use the FIPS 180-4 64-bit values.
  - SHA-256 and SHA-224 use the 32-bit values, zero-extended to WORD_W.
  - SHA-224 words: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
- Illegal mode: WORD_W=32 with a 512/384 request sets err and goes to IDLE; H is unchanged.
- ACCUM:
  - wv_ready=1.
  - On wv_valid && wv_ready: for each lane, H[k] <= H[k] + lane, where k = beat_cnt*LANES+i; then beat_cnt++.
  - 256/224 modes: add mod 2^32 on bits [31:0]; upper bits forced 0. 512/384 modes: add mod 2^64. Carries never cross words.
- Final beat (beat_cnt == BEATS-1):
  - beat_cnt wraps to 0; blk_done pulses the following cycle.
  - wv_last_blk sampled here only: 1 -> DIGEST; 0 -> stay in ACCUM for the next block, chaining from the updated H.
  - wv_last_blk on non-final beats is ignored.
- DIGEST:
  - wv_ready=0; digest_valid=1; digest stable until the transfer.
  - On digest_ready: next state IDLE, digest_valid=0. H retains its value.
- Digest packing (32-bit words in 256/224 modes):
  - SHA-512: {H0..H7}.
  - SHA-384: {H0..H5} in [383:0].
  - SHA-256: {H0..H7} in [255:0].
  - SHA-224: {H0..H6} in [223:0].
- IDLE: wv_ready=0; beats ignored.
- h_state reflects the registers with no added latency. Feed-forward result is visible the cycle after the final beat, coincident with blk_done.

Test Plan:
- Reset, LANES=2: h_state H0=0000_0000_6a09e667; wv_ready=0, digest_valid=0, err=0.
- SHA-256, one block, all eight words 0x1, last_blk=1 on beat 3: blk_done pulses once; digest[255:224]=6a09e668, digest[31:0]=5be0cd1a, digest[511:256]=0.
- 32-bit wrap, SHA-256, word a=ffffffff_ffffffff: H0 becomes 0000_0000_6a09e666. No cross-word carry: in SHA-512, a=0000_0000_0c4336f8 gives H0=6a09e668_00000000.
- Two-block SHA-224, each block all words 0x1: after block 1 blk_done pulses and state stays ACCUM; after block 2 digest[223:192]=c1059eda; digest[255:224]=0.
- Backpressure: hold digest_ready=0 for 10 cycles -> digest_valid stays 1 with digest unchanged; then digest_ready=1 -> digest_valid=0 the next cycle.
- Abort and error:
  - msg_start with SHA-384 while beat 2 is valid -> beat dropped; H = SHA-384 IV; beat_cnt restarts at 0.
  - WORD_W=32 instance with hash_size=00 -> err=1, state IDLE.
